// File: rtl/jpeg_pkg.sv
// Shared JPEG scan-scheduling definitions.
//   MAX_COMP           : maximum components per frame
//   BLOCK_DIM          : edge length of a DCT block in pixels
//   MAX_BLOCKS_PER_MCU : upper bound on sum(H*V) over the components of an MCU
//   comp_cfg_t         : captured per-component sampling factors and quant table id
//   sched_state_e      : block scheduler states
package jpeg_pkg;

  localparam int unsigned MAX_COMP           = 3;
  localparam int unsigned BLOCK_DIM          = 8;
  localparam int unsigned MAX_BLOCKS_PER_MCU = 10;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] v;
    logic [1:0] qt;
  } comp_cfg_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_CALC  = 2'd2,
    S_ISSUE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/mcu_geometry.sv
// MCU grid size from captured frame dimensions.
//   clk, rst_n      : clock, synchronous active-low reset
//   load            : register a new grid size (scheduler CALC cycle)
//   h_two, v_two    : per used component, horizontal/vertical factor is 2
//   width, height   : frame size in pixels
//   mcus_x, mcus_y  : MCU columns / rows, registered
module mcu_geometry #(
  parameter int unsigned MAX_COMP = 3,
  parameter int unsigned DIM_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [MAX_COMP-1:0] h_two,
  input  logic [MAX_COMP-1:0] v_two,
  input  logic [DIM_W-1:0]    width,
  input  logic [DIM_W-1:0]    height,
  output logic [DIM_W-1:0]    mcus_x,
  output logic [DIM_W-1:0]    mcus_y
);
  import jpeg_pkg::*;

  localparam int unsigned SHIFT = $clog2(BLOCK_DIM);

  logic           hmax_two;
  logic           vmax_two;
  logic [DIM_W:0] span_x;
  logic [DIM_W:0] span_y;

  // One extra bit so that width + 8*Hmax - 1 cannot wrap at full-scale width.
  always_comb begin
    hmax_two = |h_two;
    vmax_two = |v_two;
    span_x   = {1'b0, width}  + (DIM_W+1)'(hmax_two ? 2*BLOCK_DIM-1 : BLOCK_DIM-1);
    span_y   = {1'b0, height} + (DIM_W+1)'(vmax_two ? 2*BLOCK_DIM-1 : BLOCK_DIM-1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcus_x <= '0;
      mcus_y <= '0;
    end else if (load) begin
      mcus_x <= DIM_W'(span_x >> (hmax_two ? SHIFT + 1 : SHIFT));
      mcus_y <= DIM_W'(span_y >> (vmax_two ? SHIFT + 1 : SHIFT));
    end
  end

endmodule

// File: rtl/mcu_scheduler.sv
// Baseline JPEG block scheduler: validates a frame configuration on start,
// derives the MCU grid and issues one descriptor per 8x8 block in
// interleaved order over a valid/ready handshake.
//   clk, rst_n              : clock, synchronous active-low reset
//   start                   : begin a frame (IDLE only)
//   sof_components          : component count
//   img_height, img_width   : frame size in pixels
//   comp_samp               : per-component sampling byte, H in [7:4], V in [3:0]
//   comp_qt                 : per-component quant table id
//   busy, cfg_err, done     : status / one-cycle pulses
//   blk_valid, blk_ready    : descriptor handshake
//   blk_comp, blk_qt        : component and quant table of the block
//   blk_last_in_mcu, blk_last : end of MCU / end of frame markers
//   mcu_x, mcu_y            : MCU coordinates of the block
module mcu_scheduler #(
  parameter int unsigned MAX_COMP = jpeg_pkg::MAX_COMP,
  parameter int unsigned DIM_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            sof_components,
  input  logic [DIM_W-1:0]      img_height,
  input  logic [DIM_W-1:0]      img_width,
  input  logic [8*MAX_COMP-1:0] comp_samp,
  input  logic [2*MAX_COMP-1:0] comp_qt,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  done,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [1:0]            blk_comp,
  output logic [1:0]            blk_qt,
  output logic                  blk_last_in_mcu,
  output logic                  blk_last,
  output logic [DIM_W-1:0]      mcu_x,
  output logic [DIM_W-1:0]      mcu_y
);
  import jpeg_pkg::*;

  sched_state_e state, next_state;

  comp_cfg_t        cfg [MAX_COMP];
  logic [2:0]       ncomp;
  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;

  logic [DIM_W-1:0]    mcus_x;
  logic [DIM_W-1:0]    mcus_y;
  logic [MAX_COMP-1:0] used;
  logic [MAX_COMP-1:0] h_two;
  logic [MAX_COMP-1:0] v_two;
  logic [9:0]          blk_sum;
  logic                cfg_ok;

  logic [1:0] comp_idx;
  logic       h_idx;
  logic       v_idx;
  logic       last_h, last_v, last_c, last_x, last_y, mcu_end;
  logic       xfer;

  // Validation and effective sampling factors. A single-component scan is
  // non-interleaved, so its factors are treated as 1x1 once validated.
  always_comb begin
    used    = '0;
    h_two   = '0;
    v_two   = '0;
    blk_sum = '0;
    cfg_ok  = (ncomp != 3'd0) && (32'(ncomp) <= MAX_COMP) &&
              (width_q != '0) && (height_q != '0);
    for (int unsigned c = 0; c < MAX_COMP; c++) begin
      used[c]  = c < 32'(ncomp);
      h_two[c] = used[c] && (ncomp != 3'd1) && (cfg[c].h == 4'd2);
      v_two[c] = used[c] && (ncomp != 3'd1) && (cfg[c].v == 4'd2);
      if (used[c]) begin
        if (!(cfg[c].h inside {4'd1, 4'd2}) || !(cfg[c].v inside {4'd1, 4'd2}))
          cfg_ok = 1'b0;
        blk_sum = blk_sum + 10'(cfg[c].h) * 10'(cfg[c].v);
      end
    end
    if (blk_sum > 10'(MAX_BLOCKS_PER_MCU))
      cfg_ok = 1'b0;
  end

  always_comb begin
    last_h  = (h_idx == h_two[comp_idx]);
    last_v  = (v_idx == v_two[comp_idx]);
    last_c  = ({1'b0, comp_idx} == ncomp - 3'd1);
    last_x  = (mcu_x == mcus_x - DIM_W'(1));
    last_y  = (mcu_y == mcus_y - DIM_W'(1));
    mcu_end = last_h && last_v && last_c;
  end

  mcu_geometry #(
    .MAX_COMP (MAX_COMP),
    .DIM_W    (DIM_W)
  ) u_geometry (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == S_CALC),
    .h_two  (h_two),
    .v_two  (v_two),
    .width  (width_q),
    .height (height_q),
    .mcus_x (mcus_x),
    .mcus_y (mcus_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state      = state;
    busy            = (state != S_IDLE);
    blk_valid       = 1'b0;
    blk_comp        = comp_idx;
    blk_qt          = cfg[comp_idx].qt;
    case (state)
      S_IDLE:  if (start) next_state = S_CHECK;
      S_CHECK: next_state = cfg_ok ? S_CALC : S_IDLE;
      S_CALC:  next_state = S_ISSUE;
      S_ISSUE: begin
        blk_valid = 1'b1;
        if (blk_ready && mcu_end && last_x && last_y) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    xfer            = blk_valid && blk_ready;
    blk_last_in_mcu = blk_valid && mcu_end;
    blk_last        = blk_last_in_mcu && last_x && last_y;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      cfg_err <= (state == S_CHECK) && !cfg_ok;
      done    <= xfer && blk_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ncomp    <= '0;
      width_q  <= '0;
      height_q <= '0;
      for (int unsigned c = 0; c < MAX_COMP; c++) cfg[c] <= '0;
    end else if (state == S_IDLE && start) begin
      ncomp    <= sof_components;
      width_q  <= img_width;
      height_q <= img_height;
      for (int unsigned c = 0; c < MAX_COMP; c++) begin
        cfg[c].h  <= comp_samp[8*c+4 +: 4];
        cfg[c].v  <= comp_samp[8*c   +: 4];
        cfg[c].qt <= comp_qt[2*c +: 2];
      end
    end
  end

  // Block position walks h, then v, then component, then MCU raster order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      comp_idx <= '0;
      h_idx    <= 1'b0;
      v_idx    <= 1'b0;
      mcu_x    <= '0;
      mcu_y    <= '0;
    end else if (state == S_IDLE && start) begin
      comp_idx <= '0;
      h_idx    <= 1'b0;
      v_idx    <= 1'b0;
      mcu_x    <= '0;
      mcu_y    <= '0;
    end else if (xfer) begin
      if (!last_h) begin
        h_idx <= 1'b1;
      end else begin
        h_idx <= 1'b0;
        if (!last_v) begin
          v_idx <= 1'b1;
        end else begin
          v_idx <= 1'b0;
          if (!last_c) begin
            comp_idx <= comp_idx + 2'd1;
          end else begin
            comp_idx <= '0;
            if (last_x) begin
              mcu_x <= '0;
              mcu_y <= last_y ? '0 : mcu_y + DIM_W'(1);
            end else begin
              mcu_x <= mcu_x + DIM_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/mcu_scheduler.md
# mcu_scheduler

Sequences the 8x8 block stream of a baseline JPEG scan from the frame parameters produced by SOF decoding: precision-independent geometry (height, width), component count, per-component sampling factors and quantization-table selectors. On `start` it validates and captures the frame configuration, derives the MCU grid, and issues one block descriptor per 8x8 block in JPEG interleaved order over a valid/ready handshake. It sits between the header-decoding front end and the entropy-decode/dequantize/IDCT datapath, telling that datapath which component and quantization table each next block belongs to.

## Interface
- `MAX_COMP`, 3, maximum components per frame (1..4)
- `DIM_W`, 16, width of image-dimension and MCU-coordinate fields
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  begin a frame; sampled only in IDLE
- `sof_components`  in  3  component count from SOF
- `img_height`, `img_width`  in  DIM_W  frame dimensions in pixels
- `comp_samp`  in  8*MAX_COMP  per-component SOF sampling byte: [7:4]=H, [3:0]=V; component c at [8c+:8]
- `comp_qt`  in  2*MAX_COMP  per-component quantization table id 0..3
- `busy`  out  1  frame in progress (CHECK..ISSUE)
- `cfg_err`  out  1  one-cycle pulse: configuration rejected
- `done`  out  1  one-cycle pulse: last block transferred
- `blk_valid`  out  1  descriptor valid
- `blk_ready`  in  1  datapath accepts descriptor
- `blk_comp`  out  2  component index of block
- `blk_qt`  out  2  quantization table id of block
- `blk_last_in_mcu`  out  1  final block of current MCU
- `blk_last`  out  1  final block of frame
- `mcu_x`, `mcu_y`  out  DIM_W  MCU coordinates of current block

## Operation
- States: IDLE, CHECK, CALC, ISSUE. `start` in IDLE captures all config inputs into registers → CHECK; `start` elsewhere ignored.
- CHECK (1 cycle): reject if components ∉ 1..MAX_COMP, any used H or V ∉ {1,2}, sum of H*V over used components > 10, or width/height = 0. Reject → `cfg_err` pulse, → IDLE. Else → CALC.
- CALC (1 cycle): Hmax/Vmax = max over used components; mcus_x = (width + 8*Hmax − 1) >> (3 + log2 Hmax), mcus_y likewise with Vmax; intermediates DIM_W+1 bits, no overflow at width = 2^DIM_W − 1. Single-component frame: non-interleaved; Hmax=Vmax=1 for the grid and per-MCU H=V=1 regardless of declared factors.
- ISSUE: per MCU, for c = 0..N−1, v = 0..V_c−1, h = 0..H_c−1 emit one descriptor (`blk_comp`=c, `blk_qt`=comp_qt[c]). MCUs in raster order: mcu_x increments, wraps to 0 at mcus_x with mcu_y increment.
- `blk_last_in_mcu` = last (c,v,h) of MCU; `blk_last` = that AND last MCU.
- Transfer = `blk_valid && blk_ready`. After the `blk_last` transfer → IDLE, `done` pulses.

## Timing
- Reset: state IDLE; `busy`, `cfg_err`, `done`, `blk_valid`, `blk_last_in_mcu`, `blk_last` = 0; `blk_comp`, `blk_qt`, `mcu_x`, `mcu_y` = 0; all counters 0.
- `start` sampled at edge E0 → `busy`=1 after E0; `cfg_err` (if rejected) high for the cycle after E1, `busy` low same cycle; otherwise `blk_valid` first high after E2.
- Descriptor fields stable while `blk_valid && !blk_ready`; `blk_valid` never drops before a transfer.
- Back-to-back: on transfer, next descriptor presented the following cycle; no bubbles; full throughput one block/cycle with `blk_ready` tied high.
- Last transfer at edge En → after En: `blk_valid`=0, `busy`=0, `done`=1 for one cycle; `start` accepted in that same cycle.
- `rst_n` low mid-frame → reset values after that edge; partial frame discarded, no `done`.
- Config inputs not sampled after E0; changes mid-frame have no effect.

## Structure
- Shared package `jpeg_pkg`: `MAX_COMP`, `BLOCK_DIM`=8, `comp_cfg_t` struct (h, v, qt), `sched_state_e` enum, max-blocks-per-MCU constant (10).
- Sub-module `mcu_geometry`: registered Hmax/Vmax and mcus_x/mcus_y computation from captured config, used in CALC.

## Test plan
- 16x16, 3 comps, 4:2:0 (Y 0x22, Cb/Cr 0x11, qt 0,1,1), ready high → 6 blocks comp 0,0,0,0,1,2, qt 0,0,0,0,1,1, `blk_last_in_mcu` and `blk_last` on 6th, `done` next cycle.
- 17x8, 4:2:0 → mcus_x=2, mcus_y=1, 12 blocks, mcu_x 0 for blocks 1–6, 1 for 7–12.
- Grayscale 24x16, comp_samp 0x22 → non-interleaved, 6 single-block MCUs, `blk_last_in_mcu` on every block, mcu (0,0)…(2,1).
- Invalid: comp_samp[0]=0x31 → `cfg_err` one cycle after CHECK, no `blk_valid`, `busy` 0.
- Backpressure: `blk_ready` low 5 cycles on block 3 → fields and `blk_valid` held constant, sequence resumes unchanged.
- `rst_n` low on block 4 of 6 → all outputs at reset values next cycle; new `start` runs full frame correctly.
